// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and constants for the multiplexed 7-segment scan controller.
//   scan_state_t : two-phase scan FSM (all anodes off, then one digit lit)
//   NUM_DIGITS   : number of common-anode digits on the shared segment bus
//   SEG_OFF      : active-low segment pattern with every segment dark
package display_pkg;

   typedef enum logic {BLANK, SHOW} scan_state_t;

   localparam int NUM_DIGITS = 4;
   localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seven_seg.sv
// seven_seg
//   Combinational hex-to-seven-segment decoder, active-high, bit order gfedcba.
//   hexIn : 4-bit value 0-F
//   led   : 7-bit segment pattern, 1 = segment lit
module seven_seg (
   input  logic [3:0] hexIn,
   output logic [6:0] led
);

   always_comb begin
      case (hexIn)
         4'h0:    led = 7'h3F;
         4'h1:    led = 7'h06;
         4'h2:    led = 7'h5B;
         4'h3:    led = 7'h4F;
         4'h4:    led = 7'h66;
         4'h5:    led = 7'h6D;
         4'h6:    led = 7'h7D;
         4'h7:    led = 7'h07;
         4'h8:    led = 7'h7F;
         4'h9:    led = 7'h6F;
         4'hA:    led = 7'h77;
         4'hB:    led = 7'h7C;
         4'hC:    led = 7'h39;
         4'hD:    led = 7'h5E;
         4'hE:    led = 7'h79;
         default: led = 7'h71;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Scans a 15-bit word onto four common-anode 7-segment digits sharing one
//   segment bus. Each digit gets a BLANK gap (all anodes off) followed by a
//   SHOW slot. New words are staged in a pending register and only become
//   visible at the frame boundary, so a frame never mixes two words.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   data_in    : word to display (digit 3 uses the zero-extended top 3 bits)
//   load       : 1-cycle capture strobe for data_in
//   lz_blank   : suppress leading zeros on digits 3..1
//   seg        : active-low segment bus, registered
//   an         : active-low anode enables, registered
//   frame_tick : high during the last SHOW cycle of digit 3
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [14:0] data_in,
   input  logic        load,
   input  logic        lz_blank,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_t       state, nextState;
   logic [IDX_W-1:0]  idx, nextIdx;
   logic [CNT_W-1:0]  cnt, nextCnt;
   logic [14:0]       pending, shown;
   logic              pendVld;
   logic              boundary;
   logic [3:0]        nibble;
   logic [6:0]        glyph;
   logic              blank3, blank2, blank1, digitBlank;
   logic [NUM_DIGITS-1:0] anShow;

   // The shared counter runs up from 0 in BLANK (so the reset value 0 gives
   // a full first gap) and down to 0 in SHOW after being loaded.
   always_comb begin
      nextState = state;
      nextIdx   = idx;
      nextCnt   = cnt;
      case (state)
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               nextState = SHOW;
               nextCnt   = DIGIT_LAST;
            end else begin
               nextCnt = cnt + CNT_W'(1);
            end
         end
         SHOW: begin
            if (cnt == '0) begin
               nextState = BLANK;
               nextIdx   = idx + IDX_W'(1);
               nextCnt   = '0;
            end else begin
               nextCnt = cnt - CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Last SHOW cycle of the last digit: the only cycle that may swap 'shown'.
   assign boundary = (state == SHOW) && (idx == IDX_W'(NUM_DIGITS - 1)) && (cnt == '0);

   always_comb begin
      nibble = shown[3:0];
      case (idx)
         2'd0:    nibble = shown[3:0];
         2'd1:    nibble = shown[7:4];
         2'd2:    nibble = shown[11:8];
         default: nibble = {1'b0, shown[14:12]};
      endcase
   end

   // Blanking chains downward: a digit is a leading zero only if every
   // higher digit is one as well.
   assign blank3 = lz_blank && (shown[14:12] == 3'd0);
   assign blank2 = blank3 && (shown[11:8] == 4'd0);
   assign blank1 = blank2 && (shown[7:4] == 4'd0);

   always_comb begin
      digitBlank = 1'b0;
      case (idx)
         2'd3:    digitBlank = blank3;
         2'd2:    digitBlank = blank2;
         2'd1:    digitBlank = blank1;
         default: digitBlank = 1'b0;
      endcase
   end

   seven_seg decoder (
      .hexIn (nibble),
      .led   (glyph)
   );

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
         assign anShow[gi] = (idx != IDX_W'(gi));
      end
   endgenerate

   // Outputs are computed from the next state so they switch on the same
   // edge as the FSM. idx never changes on entry to SHOW, so the current
   // nibble mux already selects the digit about to be lit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= BLANK;
         idx        <= '0;
         cnt        <= '0;
         pending    <= '0;
         shown      <= '0;
         pendVld    <= 1'b0;
         seg        <= SEG_OFF;
         an         <= 4'hF;
         frame_tick <= 1'b0;
      end else begin
         state <= nextState;
         idx   <= nextIdx;
         cnt   <= nextCnt;

         if (nextState == SHOW) begin
            an  <= anShow;
            seg <= digitBlank ? SEG_OFF : ~glyph;
         end else begin
            an  <= 4'hF;
            seg <= SEG_OFF;
         end

         frame_tick <= (nextState == SHOW) && (nextIdx == IDX_W'(NUM_DIGITS - 1)) &&
                       (nextCnt == '0);

         if (boundary) begin
            // A load landing on the boundary goes straight to the display.
            if (load) begin
               shown   <= data_in;
               pendVld <= 1'b0;
            end else if (pendVld) begin
               shown   <= pending;
               pendVld <= 1'b0;
            end
         end else if (load) begin
            pending <= data_in;
            pendVld <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

   localparam int D     = 4;
   localparam int B     = 2;
   localparam int SLOT  = B + D;
   localparam int FRAME = 4 * SLOT;

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] data_in = '0;
   logic        load = 1'b0;
   logic        lz_blank = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_tick;

   display_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .load       (load),
      .lz_blank   (lz_blank),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: cycle number since reset release plus the word state.
   int          t;
   logic [14:0] mShown, mPending;
   logic        mPv;
   logic        lzCur;
   logic [3:0]  expAn;
   logic [6:0]  expSeg;
   logic        expTick;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, t);
      end
   endtask

   function automatic logic [3:0] modelAn(input int pos);
      int dig = pos / SLOT;
      if ((pos % SLOT) < B) return 4'hF;
      return ~(4'b0001 << dig);
   endfunction

   // A digit counts as a leading zero when it and every digit above it are 0.
   function automatic logic [6:0] modelSeg(input int pos, input logic [14:0] w, input logic lz);
      int dig = pos / SLOT;
      logic [14:0] upper;
      logic [3:0]  nib;
      if ((pos % SLOT) < B) return 7'h7F;
      upper = w >> (4 * dig);
      nib   = upper[3:0];
      if (lz && dig > 0 && upper == 15'd0) return 7'h7F;
      return ~GLYPH[nib];
   endfunction

   task automatic resetModel();
      t        = 0;
      mShown   = '0;
      mPending = '0;
      mPv      = 1'b0;
      expAn    = 4'hF;
      expSeg   = 7'h7F;
      expTick  = 1'b0;
   endtask

   // Entered at a negedge: check this cycle, drive inputs, advance one clock.
   task automatic cycle(input logic ld, input logic [14:0] d);
      int pos;
      check("an", 16'(an), 16'(expAn));
      check("seg", 16'(seg), 16'(expSeg));
      check("frame_tick", 16'(frame_tick), 16'(expTick));
      check("anode_onehot", 16'($countones(~an) <= 1), 16'd1);
      load     = ld;
      data_in  = d;
      lz_blank = lzCur;
      @(posedge clk);
      pos = t % FRAME;
      if (pos == FRAME - 1) begin
         if (ld) begin
            mShown = d;
            mPv    = 1'b0;
         end else if (mPv) begin
            mShown = mPending;
            mPv    = 1'b0;
         end
      end else if (ld) begin
         mPending = d;
         mPv      = 1'b1;
      end
      t++;
      expAn   = modelAn(t % FRAME);
      expSeg  = modelSeg(t % FRAME, mShown, lzCur);
      expTick = ((t % FRAME) == FRAME - 1);
      @(negedge clk);
   endtask

   task automatic idleTo(input int target);
      for (int i = 0; i < FRAME && (t % FRAME) != target; i++) cycle(1'b0, '0);
   endtask

   task automatic idleFrame();
      for (int i = 0; i < FRAME; i++) cycle(1'b0, '0);
   endtask

   initial begin
      logic [14:0] w;
      int          k;
      logic        ld;

      resetModel();
      lzCur = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Power-up scan sequence, two frames with the reset word 0
      idleFrame();
      idleFrame();

      // Tear-free load at clock 5 of a frame
      idleTo(4);
      cycle(1'b1, 15'h1234);
      idleTo(0);
      idleFrame();

      // Load on the boundary cycle bypasses pending
      idleTo(FRAME - 1);
      cycle(1'b1, 15'h0ABC);
      // Double load inside one frame: last one wins
      idleTo(3);
      cycle(1'b1, 15'h0001);
      idleTo(10);
      cycle(1'b1, 15'h0002);
      idleTo(0);
      idleFrame();

      // Leading-zero suppression
      lzCur = 1'b1;
      idleTo(2);
      cycle(1'b1, 15'h0005);
      idleTo(0);
      idleFrame();
      cycle(1'b1, 15'h0105);
      idleTo(0);
      idleFrame();
      cycle(1'b1, 15'h0000);
      idleTo(0);
      idleFrame();

      // Reset during digit 2 SHOW with a word still pending
      cycle(1'b1, 15'h7777);
      idleTo(2 * SLOT + B + 1);
      check("pre_reset_an", 16'(an), 16'(4'b1011));
      reset = 1'b1;
      #1;
      check("reset_an", 16'(an), 16'(4'hF));
      check("reset_seg", 16'(seg), 16'(7'h7F));
      check("reset_tick", 16'(frame_tick), 16'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      resetModel();
      idleFrame();
      idleFrame();

      // Randomized traffic: sparse loads, boundary loads, lz toggles
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 49) == 0) lzCur = ~lzCur;
         if ((t % FRAME) == FRAME - 1) ld = ($urandom_range(0, 1) == 1);
         else                          ld = ($urandom_range(0, 7) == 0);
         k = $urandom_range(0, 4);
         w = 15'($urandom) & (15'h7FFF >> (4 * k));
         cycle(ld, w);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
